// File: rtl/icache_ctrl_pkg.sv
// Shared constants, FSM state encoding and word-select helper for the icache controller.
// Optional feature macro used by icache_ctrl: ICACHE_CTRL_UNCACHED_EN.
package icache_ctrl_pkg;

    localparam int unsigned IcacheIndexLen  = 6;
    localparam int unsigned IcacheOffsetLen = 4;
    localparam int unsigned RefillBeats     = 4;
    localparam int unsigned LineLen         = 32 * RefillBeats;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLookup  = 3'd1,
        StMissReq = 3'd2,
        StRefill  = 3'd3,
        StWrite   = 3'd4,
        StResp    = 3'd5
    } state_e;

    // Word 0 lives in bits 31:0 of a line.
    function automatic logic [31:0] word_of(input logic [LineLen-1:0] line, input logic [1:0] sel);
        logic [31:0] w;
        unique case (sel)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            default: w = line[127:96];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/icache_refill_buf.sv
// Collects refill beats into one line, tracks a sticky bus error and selects one word.
module icache_refill_buf
    import icache_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               beat_valid,
    input  logic [31:0]        beat_data,
    input  logic               beat_err,
    input  logic [1:0]         word_sel,
    output logic [LineLen-1:0] line,
    output logic               err,
    output logic [31:0]        word
);

    localparam int unsigned CntW = $clog2(RefillBeats);

    logic [CntW-1:0] beat_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            line     <= '0;
            err      <= 1'b0;
        end else if (clear) begin
            beat_cnt <= '0;
            line     <= '0;
            err      <= 1'b0;
        end else if (beat_valid) begin
            for (int k = 0; k < RefillBeats; k++) begin
                if (beat_cnt == CntW'(k)) begin
                    line[32*k +: 32] <= beat_data;
                end
            end
            beat_cnt <= beat_cnt + 1'b1;
            err      <= err | beat_err;
        end
    end

    assign word = word_of(line, word_sel);

endmodule

// File: rtl/icache_ctrl.sv
// Instruction cache sequencing controller: lookup, 4-beat refill, array write and response.
// Define ICACHE_CTRL_UNCACHED_EN to bypass the array for addresses with bit 31 clear.
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int unsigned DATA_LEN  = 32,
    parameter int unsigned INDEX_LEN = IcacheIndexLen,
    parameter int unsigned TAG_LEN   = DATA_LEN - 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [DATA_LEN-1:0]  req_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [DATA_LEN-1:0]  mem_req_addr,
    output logic [1:0]           mem_req_len,
    input  logic                 mem_rsp_valid,
    input  logic [31:0]          mem_rsp_data,
    input  logic                 mem_rsp_last,
    input  logic                 mem_rsp_err,
    input  logic                 line_valid,
    input  logic [TAG_LEN-1:0]   line_tag,
    input  logic [LineLen-1:0]   line_Q,
    output logic                 line_CEN,
    output logic                 line_WEN,
    output logic [INDEX_LEN-1:0] line_A,
    output logic [LineLen-1:0]   line_BWEN,
    output logic [LineLen-1:0]   line_D,
    output logic [TAG_LEN-1:0]   line_tag_in
);

    state_e                 state;
    logic [DATA_LEN-1:0]    addr_q;
    logic [INDEX_LEN-1:0]   idx_q;
    logic                   we_q;
    logic                   bypass_q;
    logic                   req_bypass;
    logic                   rd_en;
    logic                   hit;
    logic                   refill_err;
    logic                   buf_clear;
    logic                   buf_beat;
    logic [LineLen-1:0]     buf_line;
    logic                   buf_err;
    logic [31:0]            buf_word;

`ifdef ICACHE_CTRL_UNCACHED_EN
    assign req_bypass = ~req_addr[DATA_LEN-1];
`else
    assign req_bypass = 1'b0;
`endif

    // The array read is launched in the accept cycle so line_Q is ready in LOOKUP.
    assign rd_en       = (state == StIdle) && req_valid && !req_bypass;
    assign line_CEN    = ~(rd_en | we_q);
    assign line_WEN    = ~we_q;
    assign line_A      = rd_en ? req_addr[IcacheOffsetLen +: INDEX_LEN] : idx_q;
    assign line_BWEN   = we_q ? '0 : '1;
    assign line_D      = we_q ? buf_line : '0;
    assign line_tag_in = we_q ? addr_q[DATA_LEN-1 -: TAG_LEN] : '0;

    assign hit        = line_valid && (line_tag == addr_q[DATA_LEN-1 -: TAG_LEN]);
    assign refill_err = buf_err | mem_rsp_err;
    assign buf_clear  = (state == StMissReq) && mem_req_ready;
    assign buf_beat   = (state == StRefill) && mem_rsp_valid;

    icache_refill_buf u_refill_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (buf_clear),
        .beat_valid(buf_beat),
        .beat_data (mem_rsp_data),
        .beat_err  (mem_rsp_err),
        .word_sel  (addr_q[3:2]),
        .line      (buf_line),
        .err       (buf_err),
        .word      (buf_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            addr_q        <= '0;
            idx_q         <= '0;
            we_q          <= 1'b0;
            bypass_q      <= 1'b0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_len   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        idx_q     <= req_addr[IcacheOffsetLen +: INDEX_LEN];
                        req_ready <= 1'b0;
                        bypass_q  <= req_bypass;
                        if (req_bypass) begin
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= req_addr;
                            mem_req_len   <= 2'd0;
                            state         <= StMissReq;
                        end else begin
                            state <= StLookup;
                        end
                    end
                end
                StLookup: begin
                    if (hit) begin
                        rsp_data  <= word_of(line_Q, addr_q[3:2]);
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {addr_q[DATA_LEN-1:IcacheOffsetLen], {IcacheOffsetLen{1'b0}}};
                        mem_req_len   <= 2'(RefillBeats - 1);
                        state         <= StMissReq;
                    end
                end
                StMissReq: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= StRefill;
                    end
                end
                StRefill: begin
                    if (mem_rsp_valid && mem_rsp_last) begin
                        if (refill_err || bypass_q) begin
                            rsp_data  <= refill_err ? '0 : mem_rsp_data;
                            rsp_err   <= refill_err;
                            rsp_valid <= 1'b1;
                            state     <= StResp;
                        end else begin
                            we_q  <= 1'b1;
                            state <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    we_q      <= 1'b0;
                    rsp_data  <= buf_word;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl with a behavioural line array and a directed bus responder.
module tb_icache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0]  req_addr, rsp_data;
    logic         mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_last, mem_rsp_err;
    logic [31:0]  mem_req_addr, mem_rsp_data;
    logic [1:0]   mem_req_len;
    logic         line_valid, line_CEN, line_WEN;
    logic [21:0]  line_tag, line_tag_in;
    logic [127:0] line_Q, line_BWEN, line_D;
    logic [5:0]   line_A;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_req_len  (mem_req_len),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .mem_rsp_last (mem_rsp_last),
        .mem_rsp_err  (mem_rsp_err),
        .line_valid   (line_valid),
        .line_tag     (line_tag),
        .line_Q       (line_Q),
        .line_CEN     (line_CEN),
        .line_WEN     (line_WEN),
        .line_A       (line_A),
        .line_BWEN    (line_BWEN),
        .line_D       (line_D),
        .line_tag_in  (line_tag_in)
    );

    // Line array model: flags read combinationally, data one cycle after a read.
    logic         mvalid [64];
    logic [21:0]  mtag   [64];
    logic [127:0] mdata  [64];

    assign line_valid = mvalid[line_A];
    assign line_tag   = mtag[line_A];

    always @(posedge clk) begin
        if (!line_CEN) begin
            if (!line_WEN) begin
                mdata[line_A]  <= (mdata[line_A] & line_BWEN) | (line_D & ~line_BWEN);
                mtag[line_A]   <= line_tag_in;
                mvalid[line_A] <= 1'b1;
            end else begin
                line_Q <= mdata[line_A];
            end
        end
    end

    typedef struct { logic [31:0] data; logic err; } rsp_t;
    typedef struct { logic [31:0] addr; logic [1:0] len; } mreq_t;
    typedef struct { logic [5:0] idx; logic [127:0] d; logic [21:0] tag; } wr_t;

    rsp_t  rsp_q[$];
    mreq_t mreq_q[$];
    wr_t   wr_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event did not occur or was unexpected", name);
    endtask

    // Monitors: pop the scoreboard whenever the DUT presents a transfer.
    always @(negedge clk) begin : mon
        rsp_t  er;
        mreq_t em;
        wr_t   ew;
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) fail("unexpected_rsp");
                else begin
                    er = rsp_q.pop_front();
                    chk("rsp_data", rsp_data, er.data);
                    chk("rsp_err", rsp_err, er.err);
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mreq_q.size() == 0) fail("unexpected_mem_req");
                else begin
                    em = mreq_q.pop_front();
                    chk("mem_req_addr", mem_req_addr, em.addr);
                    chk("mem_req_len", mem_req_len, em.len);
                end
            end
            if (!line_CEN && !line_WEN) begin
                if (wr_q.size() == 0) fail("unexpected_line_write");
                else begin
                    ew = wr_q.pop_front();
                    chk("wr_index", line_A, ew.idx);
                    chk("wr_data", line_D, ew.d);
                    chk("wr_tag", line_tag_in, ew.tag);
                    chk("wr_bwen", line_BWEN, 128'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a);
        int n = 0;
        while (!req_ready && n < 100) begin tick(); n++; end
        if (!req_ready) fail("req_ready_timeout");
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic serve(input logic [127:0] line, input int nbeats, input int err_beat,
                         input bit send_last);
        int n = 0;
        while (!mem_req_valid && n < 100) begin tick(); n++; end
        if (!mem_req_valid) begin
            fail("mem_req_timeout");
            return;
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = line[32*k +: 32];
            mem_rsp_last  = send_last && (k == nbeats - 1);
            mem_rsp_err   = (k == err_beat);
            tick();
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_last  = 1'b0;
        mem_rsp_err   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (rsp_q.size() != 0 && n < 100) begin tick(); n++; end
        if (rsp_q.size() != 0) fail("rsp_timeout");
        tick();
    endtask

    task automatic check_reset();
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_req_addr", mem_req_addr, 32'd0);
        chk("rst_mem_req_len", mem_req_len, 2'd0);
        chk("rst_line_CEN", line_CEN, 1'b1);
        chk("rst_line_WEN", line_WEN, 1'b1);
        chk("rst_line_A", line_A, 6'd0);
        chk("rst_line_BWEN", line_BWEN, {128{1'b1}});
        chk("rst_line_D", line_D, 128'd0);
        chk("rst_line_tag_in", line_tag_in, 22'd0);
    endtask

    localparam logic [127:0] LineA = 128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] LineB = 128'h000000a4_000000a3_000000a2_000000a1;
    localparam logic [127:0] LineC = 128'h0000c004_0000c003_0000c002_0000c001;
    localparam logic [127:0] LineD = 128'h0000d004_0000d003_0000d002_0000d001;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifdef ICACHE_CTRL_UNCACHED_EN
    logic bypass_watch = 1'b0;
    logic cen_low_seen = 1'b0;
    always @(negedge clk) if (bypass_watch && !line_CEN) cen_low_seen <= 1'b1;
`endif

    initial begin
        for (int i = 0; i < 64; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = '0;
            mdata[i]  = '0;
        end
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        mem_rsp_last = 1'b0; mem_rsp_err = 1'b0;
        repeat (3) tick();
        check_reset();
        rst = 1'b0;
        tick();

        // Cold miss: line 0x10 filled with tag 0x200000, word 1 returned.
        mreq_q.push_back('{addr: 32'h8000_0100, len: 2'd3});
        wr_q.push_back('{idx: 6'h10, d: LineA, tag: 22'h200000});
        rsp_q.push_back('{data: 32'h22, err: 1'b0});
        issue(32'h8000_0104);
        serve(LineA, 4, -1, 1'b1);
        drain();

        // Hit: response two cycles after acceptance, no bus traffic.
        rsp_q.push_back('{data: 32'h33, err: 1'b0});
        issue(32'h8000_0108);
        chk("hit_lookup_rsp_valid", rsp_valid, 1'b0);
        tick();
        chk("hit_t2_rsp_valid", rsp_valid, 1'b1);
        drain();

        // Same index, different tag: refill replaces tag 0x200000 with 0x200001.
        mreq_q.push_back('{addr: 32'h8000_0500, len: 2'd3});
        wr_q.push_back('{idx: 6'h10, d: LineB, tag: 22'h200001});
        rsp_q.push_back('{data: 32'ha2, err: 1'b0});
        issue(32'h8000_0504);
        serve(LineB, 4, -1, 1'b1);
        drain();

        // Error on beat 2: no write, error response, next access misses again.
        mreq_q.push_back('{addr: 32'h8000_0200, len: 2'd3});
        rsp_q.push_back('{data: 32'h0, err: 1'b1});
        issue(32'h8000_0204);
        serve(LineC, 4, 2, 1'b1);
        drain();
        mreq_q.push_back('{addr: 32'h8000_0200, len: 2'd3});
        wr_q.push_back('{idx: 6'h20, d: LineC, tag: 22'h200000});
        rsp_q.push_back('{data: 32'hc002, err: 1'b0});
        issue(32'h8000_0204);
        serve(LineC, 4, -1, 1'b1);
        drain();

        // Backpressure: response held stable for 5 cycles.
        rsp_ready = 1'b0;
        rsp_q.push_back('{data: 32'ha3, err: 1'b0});
        issue(32'h8000_0508);
        begin
            int n = 0;
            while (!rsp_valid && n < 20) begin tick(); n++; end
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_data", rsp_data, 32'ha3);
            chk("hold_req_ready", req_ready, 1'b0);
            tick();
        end
        rsp_ready = 1'b1;
        drain();

        // Reset in the middle of a refill, then a stray late beat.
        mreq_q.push_back('{addr: 32'h8000_0300, len: 2'd3});
        issue(32'h8000_0304);
        serve(LineD, 2, -1, 1'b0);
        rst = 1'b1;
        tick();
        check_reset();
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hdead; mem_rsp_last = 1'b1;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
        tick();
        chk("post_rst_req_ready", req_ready, 1'b1);
        chk("post_rst_rsp_valid", rsp_valid, 1'b0);
        chk("post_rst_line_CEN", line_CEN, 1'b1);
        mreq_q.push_back('{addr: 32'h8000_0300, len: 2'd3});
        wr_q.push_back('{idx: 6'h30, d: LineD, tag: 22'h200000});
        rsp_q.push_back('{data: 32'hd002, err: 1'b0});
        issue(32'h8000_0304);
        serve(LineD, 4, -1, 1'b1);
        drain();

`ifdef ICACHE_CTRL_UNCACHED_EN
        bypass_watch = 1'b1;
        mreq_q.push_back('{addr: 32'h0000_1004, len: 2'd0});
        rsp_q.push_back('{data: 32'h0000_cafe, err: 1'b0});
        issue(32'h0000_1004);
        serve(128'h0000_cafe, 1, -1, 1'b1);
        drain();
        bypass_watch = 1'b0;
        chk("bypass_line_CEN_low", cen_low_seen, 1'b0);
`endif

        repeat (3) tick();
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        chk("mreq_q_empty", 32'(mreq_q.size()), 32'd0);
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
